// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes (a - b) mod 2^WIDTH one bit per clock, LSB first,
// and reports the final borrow, a zero flag, busy while running and a one-cycle done pulse.
module serial_sub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             bw;
  logic [CNT_W-1:0] cnt;

  logic [1:0]       step;
  logic [WIDTH-1:0] res_next;

  // One full-subtractor cell: returns {borrow_next, difference_bit}.
  function automatic logic [1:0] sub_bit(input logic ai, input logic bi, input logic bin);
    logic d;
    logic bo;
    d  = ai ^ bi ^ bin;
    bo = (~ai & bi) | (~(ai ^ bi) & bin);
    return {bo, d};
  endfunction

  always_comb begin
    step     = sub_bit(a_sh[0], b_sh[0], bw);
    res_next = {step[0], res_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      bw         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            bw    <= 1'b0;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh <= res_next;
          bw     <= step[1];
          cnt    <= cnt + 1'b1;
          // The last bit lands straight in the outputs so done coincides with valid results.
          if (cnt == LAST_BIT) begin
            diff       <= res_next;
            borrow_out <= step[1];
            zero       <= (res_next == '0);
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub (WIDTH = 32): directed operations with literal expectations,
// plus a cycle-level arithmetic model compared against every output on each cycle.
module tb_serial_sub;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         zero;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .diff       (diff),
    .borrow_out (borrow_out),
    .zero       (zero),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: an accepted start schedules result a-b to appear W edges later.
  int           m_left = 0;
  logic         m_done = 0;
  logic [W-1:0] m_diff = '0;
  logic         m_bw   = 0;
  logic         m_z    = 0;
  logic [W-1:0] p_diff = '0;
  logic         p_bw   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_done = 0;
      m_diff = '0;
      m_bw   = 0;
      m_z    = 0;
    end else if (m_left > 0) begin
      m_left--;
      m_done = (m_left == 0);
      if (m_left == 0) begin
        m_diff = p_diff;
        m_bw   = p_bw;
        m_z    = (p_diff == '0);
      end
    end else begin
      m_done = 0;
      if (start) begin
        p_diff = a - b;
        p_bw   = (a < b);
        m_left = W;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy",   64'(busy),       64'(m_left > 0));
      chk("model_done",   64'(done),       64'(m_done));
      chk("model_diff",   64'(diff),       64'(m_diff));
      chk("model_borrow", 64'(borrow_out), 64'(m_bw));
      chk("model_zero",   64'(zero),       64'(m_z));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done with a bound; returns edges elapsed (or -1 on timeout).
  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (1) begin
      tick();
      n++;
      if (done) break;
      if (n >= bound) begin
        n = -1;
        break;
      end
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input logic ez);
    int n;
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    chk({nm, "_busy0"}, 64'(busy), 64'd1);
    wait_done(W + 8, n);
    chk({nm, "_latency"}, 64'(n), 64'(W));
    chk({nm, "_diff"},   64'(diff),       64'(ed));
    chk({nm, "_borrow"}, 64'(borrow_out), 64'(eb));
    chk({nm, "_zero"},   64'(zero),       64'(ez));
    chk({nm, "_busy_end"}, 64'(busy), 64'd0);
    tick();
    chk({nm, "_done_once"}, 64'(done), 64'd0);
    chk({nm, "_hold"}, 64'(diff), 64'(ed));
  endtask

  initial begin
    int n;
    int ndone;
    logic [W-1:0] seen;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick();
    tick();
    chk_en = 1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_diff", 64'(diff), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    rst = 1'b0;

    run_op("sub_5_3", 32'd5, 32'd3, 32'd2, 1'b0, 1'b0);
    run_op("sub_0_1", 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("sub_eq", 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    run_op("sub_big", 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5679, 1'b1, 1'b0);

    // Start re-pulsed mid-operation must be ignored.
    a = 32'd7; b = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    a = 32'd9; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; seen = '0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) begin
        ndone++;
        seen = diff;
      end
    end
    chk("repulse_dones", 64'(ndone), 64'd1);
    chk("repulse_diff",  64'(seen),  64'd5);

    // Back-to-back: start held in the DONE cycle.
    a = 32'h20; b = 32'h1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(W + 8, n);
    chk("b2b_first_diff", 64'(diff), 64'h1F);
    a = 32'h10; b = 32'h1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_hold", 64'(diff), 64'h1F);
    wait_done(W + 8, n);
    chk("b2b_latency", 64'(n), 64'(W));
    chk("b2b_second_diff", 64'(diff), 64'hF);
    tick();

    // Reset at RUN cycle 10 aborts with no done pulse, then restart immediately.
    a = 32'd5; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_diff", 64'(diff), 64'd0);
    rst = 1'b0;
    run_op("after_rst", 32'd5, 32'd3, 32'd2, 1'b0, 1'b0);

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
